ship_renderer: RTL



---
 rtl/starflux_pkg.sv | 20 ++
 rtl/ship_sprite_rom.sv | 17 +
 rtl/ship_renderer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/starflux_pkg.sv
// Shared constants and types for the starflux display pipeline.
// Screen geometry, palette and the renderer state encoding live here.
package starflux_pkg;

   localparam int unsigned SCREEN_W = 160;
   localparam int unsigned SCREEN_H = 120;
   localparam int unsigned SPRITE_W = 8;
   localparam int unsigned X_MAX    = SCREEN_W - SPRITE_W;

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] WHITE = 3'b111;

   typedef enum logic [1:0] {
      StIdle,
      StErase,
      StDraw,
      StDone
   } render_state_e;

endpackage

// File: rtl/ship_sprite_rom.sv
// Combinational 8x8 sprite bit lookup; row-major, MSB is row 0 / column 0.
// Shared by the player and enemy renderers with different SPRITE shapes.
module ship_sprite_rom #(
   parameter logic [63:0] SPRITE = 64'h18183C7EFFFF2424
) (
   input  logic [2:0] row,
   input  logic [2:0] col,
   output logic       pixel
);

   logic [5:0] bit_idx;

   // {~row, ~col} == 63 - 8*row - col
   assign bit_idx = {~row, ~col};
   assign pixel   = SPRITE[bit_idx];

endmodule

// File: rtl/ship_renderer.sv
// Erases the player ship at its last position and redraws it at the new one,
// one pixel per clock, through the VGA adapter plot/x/y/colour write port.
module ship_renderer
   import starflux_pkg::*;
#(
   parameter logic [6:0]  SHIP_Y      = 7'd110,
   parameter logic [2:0]  SHIP_COLOUR = WHITE,
   parameter logic [2:0]  BG_COLOUR   = BLACK,
   parameter logic [63:0] SPRITE      = 64'h18183C7EFFFF2424
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] x_val,
   input  logic       frame_tick,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   localparam logic [7:0] XMax    = 8'(X_MAX);
   localparam logic [5:0] LastIdx = 6'd63;

   render_state_e state_q, state_d;
   logic [5:0]    idx_q, idx_d;
   logic [7:0]    new_x_q, new_x_d;
   logic [7:0]    old_x_q, old_x_d;
   logic          drawn_valid_q, drawn_valid_d;

   logic [7:0]    x_draw;
   logic [2:0]    row;
   logic [2:0]    col;
   logic          sprite_bit;

   assign x_draw = (x_val > XMax) ? XMax : x_val;
   assign row    = idx_q[5:3];
   assign col    = idx_q[2:0];

   ship_sprite_rom #(
      .SPRITE(SPRITE)
   ) u_sprite_rom (
      .row  (row),
      .col  (col),
      .pixel(sprite_bit)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= StIdle;
         idx_q         <= '0;
         new_x_q       <= '0;
         old_x_q       <= '0;
         drawn_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         new_x_q       <= new_x_d;
         old_x_q       <= old_x_d;
         drawn_valid_q <= drawn_valid_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      new_x_d       = new_x_q;
      old_x_d       = old_x_q;
      drawn_valid_d = drawn_valid_q;

      unique case (state_q)
         StIdle: begin
            if (frame_tick) begin
               new_x_d = x_draw;
               idx_d   = '0;
               if (drawn_valid_q && (x_draw == old_x_q)) begin
                  state_d = StDone;
               end else if (drawn_valid_q) begin
                  state_d = StErase;
               end else begin
                  state_d = StDraw;
               end
            end
         end
         StErase: begin
            if (idx_q == LastIdx) begin
               idx_d   = '0;
               state_d = StDraw;
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end
         StDraw: begin
            if (idx_q == LastIdx) begin
               idx_d         = '0;
               old_x_d       = new_x_q;
               drawn_valid_d = 1'b1;
               state_d       = StDone;
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Frame-buffer write port is driven only while walking the sprite.
   always_comb begin
      plot   = 1'b0;
      vga_x  = '0;
      vga_y  = '0;
      colour = BG_COLOUR;

      unique case (state_q)
         StErase: begin
            plot   = 1'b1;
            vga_x  = old_x_q + {5'd0, col};
            vga_y  = SHIP_Y + {4'd0, row};
            colour = BG_COLOUR;
         end
         StDraw: begin
            plot   = 1'b1;
            vga_x  = new_x_q + {5'd0, col};
            vga_y  = SHIP_Y + {4'd0, row};
            colour = sprite_bit ? SHIP_COLOUR : BG_COLOUR;
         end
         default: begin
         end
      endcase
   end

   assign busy = (state_q != StIdle);
   assign done = (state_q == StDone);

endmodule
